// File: rtl/b14_bus_pkg.sv
// Shared constants and types for the b14 processor bus.
// Imported by the memory responder and its interface.
package b14_bus_pkg;

  localparam int BUS_AW = 20;
  localparam int DW     = 31;

  typedef logic [DW-1:0] word_t;

  typedef enum logic {
    INIT,
    READY
  } resp_state_t;

endpackage

// File: rtl/b14_mem_responder_if.sv
// b14 bus plus side-band load port between initiator and memory.
// The responder drives datai, busy and ld_ready.
interface b14_mem_responder_if
  import b14_bus_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = b14_bus_pkg::DW
);

  logic [BUS_AW-1:0] addr;
  logic [DW-1:0]     datao;
  logic              rd;
  logic              wr;
  logic [DW-1:0]     datai;
  logic              busy;

  logic              ld_valid;
  logic              ld_ready;
  logic [AW-1:0]     ld_addr;
  logic [DW-1:0]     ld_data;

  modport master (
    output addr, datao, rd, wr,
    output ld_valid, ld_addr, ld_data,
    input  datai, busy, ld_ready
  );

  modport slave (
    input  addr, datao, rd, wr,
    input  ld_valid, ld_addr, ld_data,
    output datai, busy, ld_ready
  );

endinterface

// File: rtl/b14_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// clr_i is synchronous and wins over inc_i.
module b14_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/b14_mem_responder.sv
// Memory-side responder for the b14 bus: self-clearing RAM,
// zero-latency reads, load port, sticky OOB flag, access counters.
module b14_mem_responder
  import b14_bus_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DW    = b14_bus_pkg::DW,
  parameter int CNT_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  b14_mem_responder_if.slave   bus,
  output logic                 err_oob,
  output logic [CNT_W-1:0]     rd_count,
  output logic [CNT_W-1:0]     wr_count
);

  localparam int DEPTH = 2 ** AW;

  resp_state_t state_q, state_d;
  logic [AW-1:0] clear_idx_q, clear_idx_d;
  logic          err_q, err_d;

  logic [DW-1:0] mem_q [DEPTH];

  logic          ready;
  logic          in_range;
  logic [AW-1:0] idx;
  logic          bus_we;
  logic          ld_we;
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;

  assign ready    = (state_q == READY);
  assign in_range = (bus.addr[BUS_AW-1:AW] == '0);
  assign idx      = bus.addr[AW-1:0];

  assign bus.busy     = (state_q == INIT);
  assign bus.ld_ready = ready && !bus.wr;
  assign bus.datai    = (ready && bus.rd && in_range)
                      ? mem_q[idx] : '0;

  assign bus_we = ready && bus.wr && in_range;
  assign ld_we  = bus.ld_valid && bus.ld_ready;

  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    unique case (state_q)
      INIT: begin
        clear_idx_d = clear_idx_q + AW'(1);
        if (clear_idx_q == '1) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (ready && (bus.rd || bus.wr) && !in_range) begin
      err_d = 1'b1;
    end
  end

  // Clear beats bus write beats load; ld_ready already excludes wr.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = '0;
    mem_wd = '0;
    if (!reset) begin
      unique case (1'b1)
        bus.busy: begin
          mem_we = 1'b1;
          mem_wa = clear_idx_q;
        end
        bus_we: begin
          mem_we = 1'b1;
          mem_wa = idx;
          mem_wd = bus.datao;
        end
        ld_we: begin
          mem_we = 1'b1;
          mem_wa = bus.ld_addr;
          mem_wd = bus.ld_data;
        end
        default: mem_we = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= INIT;
      clear_idx_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_wa] <= mem_wd;
    end
  end

  assign err_oob = err_q;

  b14_sat_counter #(.WIDTH(CNT_W)) u_rd_cnt (
    .clk_i   (clock),
    .clr_i   (reset),
    .inc_i   (ready && bus.rd),
    .count_o (rd_count)
  );

  b14_sat_counter #(.WIDTH(CNT_W)) u_wr_cnt (
    .clk_i   (clock),
    .clr_i   (reset),
    .inc_i   (bus_we),
    .count_o (wr_count)
  );

endmodule

// File: tb/tb_b14_mem_responder.sv
// Random and directed bench for b14_mem_responder (AW=4, CNT_W=4)
// against a word-array model of the memory and its counters.
module tb_b14_mem_responder;
  import b14_bus_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic clock;
  logic reset;
  logic err_oob;
  logic [CNT_W-1:0] rd_count;
  logic [CNT_W-1:0] wr_count;

  b14_mem_responder_if #(.AW(AW)) bus ();

  b14_mem_responder #(
    .AW(AW), .CNT_W(CNT_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .bus      (bus.slave),
    .err_oob  (err_oob),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  word_t m_mem [DEPTH];
  int    m_left;
  bit    m_known = 1'b0;
  bit    m_err;
  int    m_rdc;
  int    m_wrc;

  task automatic check_eq(input string tag,
                          input logic [31:0] got,
                          input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r,
                      input logic [19:0] a,
                      input logic rdi,
                      input logic wri,
                      input word_t d,
                      input logic lv,
                      input logic [AW-1:0] la,
                      input word_t ldd);
    bit    inr;
    bit    bsy;
    word_t exp_d;
    reset        = r;
    bus.addr     = a;
    bus.rd       = rdi;
    bus.wr       = wri;
    bus.datao    = d;
    bus.ld_valid = lv;
    bus.ld_addr  = la;
    bus.ld_data  = ldd;
    inr = (a < 20'(DEPTH));
    #4;
    if (m_known) begin
      bsy   = (m_left > 0);
      exp_d = (!bsy && rdi && inr) ? m_mem[a[AW-1:0]] : '0;
      check_eq("busy", 32'(bus.busy), 32'(bsy));
      check_eq("ld_ready", 32'(bus.ld_ready), 32'(!bsy && !wri));
      check_eq("datai", 32'(bus.datai), 32'(exp_d));
      check_eq("err_oob", 32'(err_oob), 32'(m_err));
      check_eq("rd_count", 32'(rd_count), 32'(m_rdc));
      check_eq("wr_count", 32'(wr_count), 32'(m_wrc));
    end
    @(posedge clock);
    if (r) begin
      m_known = 1'b1;
      m_left  = DEPTH;
      m_err   = 1'b0;
      m_rdc   = 0;
      m_wrc   = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        foreach (m_mem[i]) m_mem[i] = '0;
      end
    end else begin
      if (rdi && m_rdc < CMAX) m_rdc++;
      if ((rdi || wri) && !inr) m_err = 1'b1;
      if (wri && inr) begin
        m_mem[a[AW-1:0]] = d;
        if (m_wrc < CMAX) m_wrc++;
      end else if (!wri && lv) begin
        m_mem[la] = ldd;
      end
    end
    #1;
  endtask

  task automatic idle(input logic r);
    step(r, '0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic rd_at(input logic [19:0] a);
    step(1'b0, a, 1'b1, 1'b0, '0, 1'b0, '0, '0);
  endtask

  initial begin
    logic [19:0] a;
    logic        r;
    reset = 1'b1;
    bus.addr = '0;
    bus.rd = 1'b0;
    bus.wr = 1'b0;
    bus.datao = '0;
    bus.ld_valid = 1'b0;
    bus.ld_addr = '0;
    bus.ld_data = '0;
    @(posedge clock);
    #1;

    repeat (3) idle(1'b1);
    repeat (DEPTH + 1) idle(1'b0);
    for (int i = 0; i < DEPTH; i++) rd_at(20'(i));

    idle(1'b1);
    repeat (5) idle(1'b0);
    idle(1'b1);
    repeat (DEPTH + 1) idle(1'b0);

    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 4'h3, 31'h12345678);
    rd_at(20'h00003);
    rd_at(20'h00003);

    step(1'b0, 20'h00005, 1'b1, 1'b1, 31'h7FFFFFFF,
         1'b0, '0, '0);
    rd_at(20'h00005);

    step(1'b0, 20'h00002, 1'b0, 1'b1, 31'h1,
         1'b1, 4'h2, 31'h5A5A5A5);
    rd_at(20'h00002);
    step(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 4'h2, 31'h5A5A5A5);
    rd_at(20'h00002);

    step(1'b0, 20'hFFFFF, 1'b0, 1'b1, 31'h33, 1'b0, '0, '0);
    rd_at(20'h00010);
    repeat (3) idle(1'b0);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) a = 20'($urandom);
      else a = 20'($urandom_range(0, DEPTH - 1));
      r = ($urandom_range(0, 199) == 0);
      step(r, a, 1'($urandom), 1'($urandom_range(0, 2) == 0),
           31'($urandom), 1'($urandom),
           4'($urandom), 31'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/b14_mem_responder.md
Name: b14_mem_responder

Overview:
- Memory-side responder for the b14 processor bus: serves the processor's addr/rd/wr/datao requests and drives datai.
- Holds a 2**AW-word, 31-bit memory. After reset it clears itself word by word, then serves the bus.
- Offers a side-band load port for preloading programs, sticky out-of-range error detection and saturating access counters for verification.

Parameters:
- AW, 10, memory index width; DEPTH = 2**AW words.
- DW, 31, data word width; must match the processor's datai/datao.
- CNT_W, 16, width of rd_count and wr_count.

Ports:
- clock  in  1  single system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- addr  in  20  bus address from initiator.
- datao  in  DW  write data from initiator.
- rd  in  1  read request, level.
- wr  in  1  write request, level.
- datai  out  DW  read data to initiator.
- busy  out  1  high while the post-reset memory clear runs.
- ld_valid  in  1  load request.
- ld_ready  out  1  load accepted this cycle when high with ld_valid.
- ld_addr  in  AW  load word index.
- ld_data  in  DW  load word.
- err_oob  out  1  sticky out-of-range access flag.
- rd_count  out  CNT_W  read-cycle count.
- wr_count  out  CNT_W  committed bus-write count.

Behaviour:
- Clock/reset: one clock; reset is synchronous and active-high. Ports are named clock and reset.
- States: INIT, READY.
  - Reset forces state=INIT, clear_idx=0, err_oob=0, rd_count=0, wr_count=0.
  - Reset asserted mid-clear or mid-operation restarts the clear at index 0. Memory contents are otherwise not reset.
- INIT:
  - Each non-reset edge writes mem[clear_idx]=0 and increments clear_idx.
  - The edge that writes index DEPTH-1 moves the block to READY.
  - busy = (state==INIT), so busy is 1 during and after reset and falls exactly DEPTH edges after reset deasserts.
  - In INIT: datai=0, ld_ready=0, bus writes and loads are ignored and not counted, err_oob is not updated.
- In-range test: addr[19:AW]==0. Index = addr[AW-1:0].
- Read (READY):
  - datai = (rd && in-range) ? mem[index] : 0, combinational from addr. Zero latency is required because the initiator samples datai on the edge after it registers addr.
  - Read-during-write to the same index returns the old contents in that cycle; the new value is visible from the next cycle.
- Write (READY):
  - Level-qualified: every edge with wr=1 and in-range writes mem[index]=datao and increments wr_count.
  - Out-of-range writes are dropped.
- Load port: ld_ready = (state==READY) && !wr, combinational.
  - An edge with ld_valid && ld_ready writes mem[ld_addr]=ld_data.
  - Bus write always has priority; a load held during wr stalls until wr drops.
  - Loads do not touch the counters.
- err_oob: set on any READY edge with (rd||wr) && !in-range. Cleared only by reset.
- rd_count: +1 on each READY edge with rd=1, in or out of range.
- Counters saturate at all-ones and never wrap.
- Reset values: datai=0, busy=1, ld_ready=0, err_oob=0, rd_count=0, wr_count=0.

Decomposition:
- Shared package b14_bus_pkg holds:
  - BUS_AW=20 and DW=31 constants.
  - the word_t typedef.
  - the resp_state_t enum {INIT, READY}.
- One sub-module, b14_sat_counter (parameter width; inputs inc and clr), instantiated for rd_count and wr_count.

Test Plan:
- Reset, AW=4: hold reset 3 cycles, release -> busy=1 for exactly 16 edges then 0; every index reads 0; ld_ready rises with busy falling.
- Reset mid-clear: release reset, reassert after 5 edges, release -> busy stays high 16 further edges; ld_ready=0 throughout.
- Load then read: ld 0x3=0x12345678, rd=1 addr=0x00003 -> datai=0x12345678 same cycle; rd_count increments by 1 per rd-high edge.
- Bus write and read-during-write: wr=1 addr=0x00005 datao=0x7FFFFFFF with rd=1 -> datai shows old value (0) that cycle and 0x7FFFFFFF next cycle; wr_count=1.
- Write-over-load priority: ld_valid=1 ld_addr=2 concurrent with wr=1 addr=2 datao=0x1 -> ld_ready=0, mem[2]=0x1; after wr drops, load commits and mem[2]=ld_data.
- Out of range: rd=1 addr=0x00010 with AW=4 -> datai=0, err_oob=1 on next edge and it stays 1 until reset; wr to 0xFFFFF drops the write and leaves wr_count unchanged.
